tdm_demux_1to8: RTL

//  Receive end of the 8:1 channel multiplexer: rebuilds 8 channels from one time-division stream.
//  An internal slot counter, aligned by a frame-sync strobe, routes the input to channel slot[SEL_W-1:0].

---
 rtl/tdm_demux_1to8.sv | 106 ++++++++++
 1 files changed

// File: rtl/tdm_demux_1to8.sv
// rtl/tdm_demux_1to8.sv - 1:8 time-division demultiplexer with frame-sync lock and framing-error detect
module tdm_demux_1to8 #(
    parameter  int WIDTH       = 1,
    parameter  int N_CH        = 8,
    parameter  bit STRICT_SYNC = 1'b1,
    localparam int SEL_W       = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  en,
    input  logic                  sync,
    output logic [N_CH*WIDTH-1:0] ch_out,
    output logic                  frame_vld,
    output logic [SEL_W-1:0]      slot,
    output logic                  locked,
    output logic                  sync_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_CH - 1);

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        slot_q, slot_d;
    logic [N_CH*WIDTH-1:0]   shadow_q, shadow_d;
    logic [N_CH*WIDTH-1:0]   ch_out_q, ch_out_d;
    logic                    frame_vld_q, frame_vld_d;
    logic                    sync_err_q, sync_err_d;

    // Slot sequencing: acquire lock on sync, collect slots into the shadow, publish on the last slot
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        ch_out_d    = ch_out_q;
        frame_vld_d = 1'b0;
        sync_err_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    // Without sync the sample cannot be placed, so it is silently dropped
                    if (sync) begin
                        shadow_d[WIDTH-1:0] = din;
                        slot_d              = SEL_W'(1);
                        state_d             = RUN;
                    end
                end
                RUN: begin
                    if ((slot_q != '0) && sync) begin
                        // Early sync: trust the marker, restart the frame, drop the partial one
                        sync_err_d          = 1'b1;
                        shadow_d[WIDTH-1:0] = din;
                        slot_d              = SEL_W'(1);
                    end else if ((slot_q == '0) && !sync && STRICT_SYNC) begin
                        // Missing marker on slot 0: alignment is no longer trusted
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        shadow_d[int'(slot_q)*WIDTH +: WIDTH] = din;
                        slot_d = slot_q + SEL_W'(1);
                        if (slot_q == LAST_SLOT) begin
                            // Last slot bypasses the shadow so the frame is published next edge
                            ch_out_d    = {din, shadow_q[(N_CH-1)*WIDTH-1:0]};
                            frame_vld_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            shadow_q    <= '0;
            ch_out_q    <= '0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            ch_out_q    <= ch_out_d;
            frame_vld_q <= frame_vld_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign ch_out    = ch_out_q;
    assign frame_vld = frame_vld_q;
    assign slot      = slot_q;
    assign locked    = (state_q == RUN);
    assign sync_err  = sync_err_q;

endmodule
